// File: rtl/bitonic_pkg.sv
// Shared definitions for the sequential 8-input bitonic sorter: state encoding,
// pass schedule and the per-pass compare-exchange pair/direction tables.
package bitonic_pkg;

    typedef enum logic [1:0] {
        LOAD = 2'd0,
        SORT = 2'd1,
        OUT  = 2'd2
    } state_t;

    localparam int N        = 8;
    localparam int NUM_PASS = 6;
    localparam int NUM_UNIT = N / 2;
    localparam int IDX_W    = 3;

    typedef logic [IDX_W-1:0] idx_t;
    typedef logic [2:0]       pass_t;

    typedef struct packed {
        logic [3:0] k;
        logic [2:0] j;
    } kj_t;

    localparam kj_t PASS_KJ [NUM_PASS] = '{
        '{k: 4'd2, j: 3'd1},
        '{k: 4'd4, j: 3'd2},
        '{k: 4'd4, j: 3'd1},
        '{k: 4'd8, j: 3'd4},
        '{k: 4'd8, j: 3'd2},
        '{k: 4'd8, j: 3'd1}
    };

    // lo/hi are memory indices of a pair (lo < hi); desc puts the maximum at lo.
    typedef struct packed {
        idx_t lo;
        idx_t hi;
        logic desc;
    } pair_t;

    typedef pair_t [NUM_UNIT-1:0] pair_row_t;

    function automatic pair_row_t build_row(input pass_t pass);
        pair_row_t  row;
        logic [1:0] u;
        int         p;
        row = '0;
        u   = 2'd0;
        for (int i = 0; i < N; i++) begin
            p = i ^ int'(PASS_KJ[pass].j);
            if (p > i) begin
                row[u].lo   = idx_t'(i);
                row[u].hi   = idx_t'(p);
                row[u].desc = ((i & int'(PASS_KJ[pass].k)) != 0);
                u           = u + 2'd1;
            end
        end
        return row;
    endfunction

    localparam pair_row_t PAIR_TAB [NUM_PASS] = '{
        build_row(3'd0), build_row(3'd1), build_row(3'd2),
        build_row(3'd3), build_row(3'd4), build_row(3'd5)
    };

endpackage

// File: rtl/bitonic_sort_seq_ctrl_if.sv
// Producer/consumer handshake bundle of the sequential bitonic sorter.
interface bitonic_sort_seq_ctrl_if #(
    parameter int DATA_W = 8
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] number_in;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] number_out;
    logic              out_last;
    logic              busy;

    modport master (
        output in_valid, number_in, out_ready,
        input  in_ready, out_valid, number_out, out_last, busy
    );

    modport slave (
        input  in_valid, number_in, out_ready,
        output in_ready, out_valid, number_out, out_last, busy
    );
endinterface

// File: rtl/bitonic_cmp_swap.sv
// Combinational compare-exchange unit; lo feeds the lower memory index of the pair.
module bitonic_cmp_swap #(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic              dir,
    output logic [DATA_W-1:0] lo,
    output logic [DATA_W-1:0] hi
);
    logic swap_s;

    // Strict compares so equal keys stay where they are.
    always_comb begin
        swap_s = 1'b0;
        if (dir) begin
            swap_s = (a < b);
        end else begin
            swap_s = (a > b);
        end
        if (swap_s) begin
            lo = b;
            hi = a;
        end else begin
            lo = a;
            hi = b;
        end
    end
endmodule

// File: rtl/bitonic_sort_seq_ctrl.sv
// Serial-in/serial-out 8-entry bitonic sorter: load, six shared-network passes, drain.
module bitonic_sort_seq_ctrl
    import bitonic_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    bitonic_sort_seq_ctrl_if.slave bus
);
    localparam pass_t LAST_PASS = pass_t'(NUM_PASS - 1);
    localparam idx_t  LAST_IDX  = idx_t'(N - 1);

    state_t            state_r, state_s;
    idx_t              in_cnt_r, in_cnt_s;
    idx_t              out_idx_r, out_idx_s;
    pass_t             pass_r, pass_s;
    logic [DATA_W-1:0] mem_r [N];
    logic [DATA_W-1:0] mem_s [N];
    pair_row_t         row_s;
    logic [DATA_W-1:0] cmp_lo_s [NUM_UNIT];
    logic [DATA_W-1:0] cmp_hi_s [NUM_UNIT];

    logic              in_ready_r, in_ready_s;
    logic              out_valid_r, out_valid_s;
    logic              out_last_r, out_last_s;
    logic              busy_r, busy_s;
    logic [DATA_W-1:0] number_out_r, number_out_s;

    assign row_s = PAIR_TAB[pass_r];

    for (genvar u = 0; u < NUM_UNIT; u++) begin : g_unit
        bitonic_cmp_swap #(.DATA_W(DATA_W)) u_cmp (
            .a   (mem_r[row_s[u].lo]),
            .b   (mem_r[row_s[u].hi]),
            .dir (row_s[u].desc),
            .lo  (cmp_lo_s[u]),
            .hi  (cmp_hi_s[u])
        );
    end

    // Next-state, counters and register-file update.
    always_comb begin
        state_s   = state_r;
        in_cnt_s  = in_cnt_r;
        out_idx_s = out_idx_r;
        pass_s    = pass_r;
        for (int m = 0; m < N; m++) begin
            mem_s[m] = mem_r[m];
        end
        case (state_r)
            LOAD: begin
                if (bus.in_valid) begin
                    mem_s[in_cnt_r] = bus.number_in;
                    if (in_cnt_r == LAST_IDX) begin
                        state_s  = SORT;
                        in_cnt_s = 3'd0;
                        pass_s   = 3'd0;
                    end else begin
                        in_cnt_s = in_cnt_r + 3'd1;
                    end
                end else begin
                    in_cnt_s = in_cnt_r;
                end
            end
            SORT: begin
                // All four pairs are disjoint, so reads of old values never collide.
                for (int u = 0; u < NUM_UNIT; u++) begin
                    mem_s[row_s[u].lo] = cmp_lo_s[u];
                    mem_s[row_s[u].hi] = cmp_hi_s[u];
                end
                if (pass_r == LAST_PASS) begin
                    state_s   = OUT;
                    out_idx_s = 3'd0;
                    pass_s    = 3'd0;
                end else begin
                    pass_s = pass_r + 3'd1;
                end
            end
            OUT: begin
                if (bus.out_ready) begin
                    if (out_idx_r == LAST_IDX) begin
                        state_s   = LOAD;
                        out_idx_s = 3'd0;
                    end else begin
                        out_idx_s = out_idx_r + 3'd1;
                    end
                end else begin
                    out_idx_s = out_idx_r;
                end
            end
            default: begin
                state_s   = LOAD;
                in_cnt_s  = 3'd0;
                out_idx_s = 3'd0;
                pass_s    = 3'd0;
            end
        endcase
    end

    // Output values for the next cycle, decoded from next state only.
    always_comb begin
        in_ready_s   = (state_s == LOAD);
        out_valid_s  = (state_s == OUT);
        busy_s       = (state_s != LOAD);
        number_out_s = {DATA_W{1'b0}};
        out_last_s   = 1'b0;
        if (state_s == OUT) begin
            number_out_s = mem_s[out_idx_s];
            out_last_s   = (out_idx_s == LAST_IDX);
        end else begin
            number_out_s = {DATA_W{1'b0}};
            out_last_s   = 1'b0;
        end
    end

    // State, register file and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r      <= LOAD;
            in_cnt_r     <= 3'd0;
            out_idx_r    <= 3'd0;
            pass_r       <= 3'd0;
            for (int m = 0; m < N; m++) begin
                mem_r[m] <= {DATA_W{1'b0}};
            end
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            out_last_r   <= 1'b0;
            busy_r       <= 1'b0;
            number_out_r <= {DATA_W{1'b0}};
        end else begin
            state_r      <= state_s;
            in_cnt_r     <= in_cnt_s;
            out_idx_r    <= out_idx_s;
            pass_r       <= pass_s;
            for (int m = 0; m < N; m++) begin
                mem_r[m] <= mem_s[m];
            end
            in_ready_r   <= in_ready_s;
            out_valid_r  <= out_valid_s;
            out_last_r   <= out_last_s;
            busy_r       <= busy_s;
            number_out_r <= number_out_s;
        end
    end

    assign bus.in_ready   = in_ready_r;
    assign bus.out_valid  = out_valid_r;
    assign bus.out_last   = out_last_r;
    assign bus.busy       = busy_r;
    assign bus.number_out = number_out_r;
endmodule

// File: tb/tb_bitonic_sort_seq_ctrl.sv
// Directed self-checking bench for bitonic_sort_seq_ctrl; inputs driven and outputs sampled on negedge.
module tb_bitonic_sort_seq_ctrl;
    logic clk;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;
    int   e_cyc;
    logic [7:0] vec  [8];
    logic [7:0] expv [8];
    logic [7:0] rv   [20][8];

    bitonic_sort_seq_ctrl_if #(.DATA_W(8)) bus ();

    bitonic_sort_seq_ctrl #(.DATA_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic do_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.number_in = 8'h00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    // Eight back-to-back transfers from vec; e_cyc is the edge count after the 8th.
    task automatic load_vec(input bit hold_valid);
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = 1'b1;
            bus.number_in = vec[i];
            @(negedge clk);
        end
        e_cyc = cyc;
        bus.in_valid  = hold_valid;
        bus.number_in = 8'h5A;
    endtask

    task automatic wait_out_valid(input string name);
        int n;
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (bus.out_valid !== 1'b1) begin
            errors++;
            $display("FAIL %s_timeout: out_valid=%b after %0d cycles, required 1", name, bus.out_valid, n);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.in_valid  = 1'b0;
        bus.number_in = 8'h00;
        bus.out_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b required 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b required 0", bus.out_valid); end
        checks++; if (bus.out_last !== 1'b0) begin errors++; $display("FAIL reset_out_last: got %b required 0", bus.out_last); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
        checks++; if (bus.number_out !== 8'h00) begin errors++; $display("FAIL reset_number_out: got %0h required 0", bus.number_out); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL post_reset_idle: in_ready=%b busy=%b required 1/0", bus.in_ready, bus.busy); end
    endtask

    task automatic test_basic_sort();
        int lat;
        do_reset();
        vec = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        expv = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8};
        load_vec(1'b1);
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL basic_in_ready_drop: in_ready=%b busy=%b required 0/1", bus.in_ready, bus.busy); end
        wait_out_valid("basic");
        lat = cyc - e_cyc + 1;
        checks++; if (lat != 7) begin errors++; $display("FAIL basic_latency: out_valid in cycle %0d after E, required 7", lat); end
        for (int o = 0; o < 8; o++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== expv[o]) begin errors++; $display("FAIL basic_out[%0d]: valid=%b data=%0h required 1/%0h", o, bus.out_valid, bus.number_out, expv[o]); end
            checks++; if (bus.out_last !== 1'(o == 7)) begin errors++; $display("FAIL basic_last[%0d]: got %b required %b", o, bus.out_last, 1'(o == 7)); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
        checks++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin errors++; $display("FAIL basic_back_to_load: out_valid=%b in_ready=%b required 0/1", bus.out_valid, bus.in_ready); end
    endtask

    task automatic test_unsigned_dup();
        do_reset();
        vec = '{8'hFF, 8'h00, 8'h80, 8'h7F, 8'h01, 8'hFE, 8'h80, 8'h00};
        expv = '{8'h00, 8'h00, 8'h01, 8'h7F, 8'h80, 8'h80, 8'hFE, 8'hFF};
        load_vec(1'b0);
        wait_out_valid("unsigned");
        for (int o = 0; o < 8; o++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== expv[o] || bus.out_last !== 1'(o == 7)) begin errors++; $display("FAIL unsigned_out[%0d]: valid=%b data=%0h last=%b required 1/%0h/%b", o, bus.out_valid, bus.number_out, bus.out_last, expv[o], 1'(o == 7)); end
            @(negedge clk);
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        vec = '{8'h33, 8'h11, 8'h99, 8'h55, 8'h22, 8'h88, 8'h44, 8'h66};
        expv = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h88, 8'h99};
        load_vec(1'b0);
        wait_out_valid("bp");
        for (int o = 0; o < 8; o++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== expv[o] || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_out[%0d]: valid=%b data=%0h in_ready=%b required 1/%0h/0", o, bus.out_valid, bus.number_out, bus.in_ready, expv[o]); end
            if (o == 2) begin
                bus.out_ready = 1'b0;
                for (int s = 0; s < 3; s++) begin
                    @(negedge clk);
                    checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== expv[2] || bus.in_ready !== 1'b0) begin errors++; $display("FAIL bp_hold[%0d]: valid=%b data=%0h in_ready=%b required 1/%0h/0", s, bus.out_valid, bus.number_out, bus.in_ready, expv[2]); end
                end
                bus.out_ready = 1'b1;
            end
            @(negedge clk);
        end
        checks++; if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release: in_ready=%b out_valid=%b required 1/0", bus.in_ready, bus.out_valid); end
    endtask

    task automatic test_input_gaps();
        do_reset();
        vec = '{8'd5, 8'd9, 8'd1, 8'd9, 8'd3, 8'd0, 8'd200, 8'd7};
        expv = '{8'd0, 8'd1, 8'd3, 8'd5, 8'd7, 8'd9, 8'd9, 8'd200};
        for (int i = 0; i < 8; i++) begin
            bus.in_valid  = 1'b0;
            bus.number_in = 8'hAA;
            @(negedge clk);
            checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0) begin errors++; $display("FAIL gap_still_loading[%0d]: in_ready=%b busy=%b required 1/0", i, bus.in_ready, bus.busy); end
            bus.in_valid  = 1'b1;
            bus.number_in = vec[i];
            @(negedge clk);
        end
        bus.number_in = 8'h5A;
        checks++; if (bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin errors++; $display("FAIL gap_sort_started: in_ready=%b busy=%b required 0/1", bus.in_ready, bus.busy); end
        wait_out_valid("gap");
        for (int o = 0; o < 8; o++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== expv[o]) begin errors++; $display("FAIL gap_out[%0d]: valid=%b data=%0h required 1/%0h", o, bus.out_valid, bus.number_out, expv[o]); end
            @(negedge clk);
        end
        bus.in_valid = 1'b0;
    endtask

    task automatic test_async_reset();
        do_reset();
        vec = '{8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
        load_vec(1'b0);
        repeat (3) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.number_out !== 8'h00) begin errors++; $display("FAIL arst_sort: in_ready=%b busy=%b out_valid=%b last=%b data=%0h required 1/0/0/0/0", bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.number_out); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vec = '{8'd40, 8'd10, 8'd30, 8'd20, 8'd80, 8'd50, 8'd70, 8'd60};
        load_vec(1'b0);
        wait_out_valid("arst_out");
        repeat (4) @(negedge clk);
        checks++; if (bus.number_out !== 8'd50) begin errors++; $display("FAIL arst_pre_out4: data=%0d required 50", bus.number_out); end
        #2 reset = 1'b1;
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.number_out !== 8'h00) begin errors++; $display("FAIL arst_out: in_ready=%b busy=%b out_valid=%b last=%b data=%0h required 1/0/0/0/0", bus.in_ready, bus.busy, bus.out_valid, bus.out_last, bus.number_out); end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vec = '{8'd3, 8'd1, 8'd2, 8'd0, 8'd7, 8'd5, 8'd6, 8'd4};
        load_vec(1'b0);
        wait_out_valid("arst_fresh");
        for (int o = 0; o < 8; o++) begin
            checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== 8'(o) || bus.out_last !== 1'(o == 7)) begin errors++; $display("FAIL arst_fresh_out[%0d]: valid=%b data=%0h last=%b required 1/%0h/%b", o, bus.out_valid, bus.number_out, bus.out_last, o, 1'(o == 7)); end
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int         f_cyc;
        int         prev_f;
        logic [7:0] t;
        for (int s = 0; s < 20; s++) begin
            for (int i = 0; i < 8; i++) begin
                rv[s][i] = 8'($urandom_range(0, 255));
            end
        end
        do_reset();
        prev_f = 0;
        bus.in_valid  = 1'b1;
        bus.number_in = rv[0][0];
        for (int s = 0; s < 20; s++) begin
            for (int i = 0; i < 8; i++) begin
                expv[i] = rv[s][i];
            end
            for (int i = 1; i < 8; i++) begin
                for (int m = i; m > 0; m--) begin
                    if (expv[m-1] > expv[m]) begin
                        t = expv[m-1]; expv[m-1] = expv[m]; expv[m] = t;
                    end
                end
            end
            f_cyc = cyc;
            checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d]: in_ready=%b required 1", s, bus.in_ready); end
            if (s > 0) begin
                checks++; if (f_cyc - prev_f != 22) begin errors++; $display("FAIL b2b_period[%0d]: %0d cycles required 22", s, f_cyc - prev_f); end
            end
            prev_f = f_cyc;
            for (int i = 0; i < 8; i++) begin
                bus.number_in = rv[s][i];
                @(negedge clk);
            end
            bus.number_in = (s < 19) ? rv[s+1][0] : 8'h00;
            wait_out_valid("b2b");
            for (int o = 0; o < 8; o++) begin
                checks++; if (bus.out_valid !== 1'b1 || bus.number_out !== expv[o] || bus.out_last !== 1'(o == 7)) begin errors++; $display("FAIL b2b_out[%0d][%0d]: valid=%b data=%0h last=%b required 1/%0h/%b", s, o, bus.out_valid, bus.number_out, bus.out_last, expv[o], 1'(o == 7)); end
                @(negedge clk);
            end
        end
        bus.in_valid = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        cyc    = 0;
        e_cyc  = 0;
        reset  = 1'b1;
        bus.in_valid  = 1'b0;
        bus.number_in = 8'h00;
        bus.out_ready = 1'b1;
        test_reset();
        test_basic_sort();
        test_unsigned_dup();
        test_backpressure();
        test_input_gaps();
        test_async_reset();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, required completion");
        $fatal(1, "watchdog expired");
    end
endmodule
